three_of_six_tx: RTL and testbench

Transmit end of the 3-of-6 link: accepts a 24-bit payload word and encodes each 3-bit group into a balanced 6-bit symbol, {d[2:0], ~d[2:0]}, which always has exactly three ones. It then serializes the resulting 48-bit codeword onto a narrower link, `SYMS_PER_BEAT` symbols per beat, with valid/ready flow control. It sits between the router core's output logic and the link wires. The link decoder at the far end reassembles the 48 bits, checks symbol balance, and recovers the payload.

---
 rtl/three_of_six_pkg.sv | 21 ++
 rtl/three_of_six_sym_enc.sv | 17 +
 rtl/three_of_six_tx.sv | 95 +++++++++
 tb/tb_three_of_six_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/three_of_six_pkg.sv
`default_nettype none
// ============================================================================
// Module      : three_of_six_pkg
// Description : Shared widths and the 3-of-6 symbol encoding function.
// Revision    : 1.0
// ============================================================================
package three_of_six_pkg;

    localparam int SYM_W     = 6;
    localparam int DATA_W    = 3;
    localparam int NSYMS     = 8;
    localparam int PAYLOAD_W = 24;
    localparam int CODE_W    = 48;

    // Data in the upper half, its complement below: always three ones.
    function automatic logic [SYM_W-1:0] enc_sym(input logic [DATA_W-1:0] d);
        return {d, ~d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/three_of_six_sym_enc.sv
`default_nettype none
// ============================================================================
// Module      : three_of_six_sym_enc
// Description : Combinational 3-bit to balanced 6-bit symbol encoder.
// Revision    : 1.0
// ============================================================================
module three_of_six_sym_enc
    import three_of_six_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [SYM_W-1:0]  sym
);

    assign sym = enc_sym(data);

endmodule
`default_nettype wire

// File: rtl/three_of_six_tx.sv
`default_nettype none
// ============================================================================
// Module      : three_of_six_tx
// Description : Encodes a 24-bit word into eight 3-of-6 symbols and
//               serializes the 48-bit codeword over a valid/ready link.
// Revision    : 1.0
// ============================================================================
module three_of_six_tx
    import three_of_six_pkg::*;
#(
    parameter int SYMS_PER_BEAT = 2
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PAYLOAD_W-1:0]              payload_in,
    input  logic                              payload_valid,
    output logic                              payload_ready,
    output logic [SYM_W*SYMS_PER_BEAT-1:0]    link_data,
    output logic                              link_valid,
    input  logic                              link_ready,
    output logic                              link_first,
    output logic                              link_last,
    output logic                              busy
);

    localparam int NBEATS = NSYMS / SYMS_PER_BEAT;
    localparam int BEAT_W = SYM_W * SYMS_PER_BEAT;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code;
    logic              w_last;
    logic              w_accept;
    logic              w_beat_acc;

    genvar k;
    generate
        for (k = 0; k < NSYMS; k++) begin : g_enc
            three_of_six_sym_enc u_enc (
                .data (payload_in[DATA_W*k +: DATA_W]),
                .sym  (w_code[SYM_W*k +: SYM_W])
            );
        end
    endgenerate

    assign w_last        = (r_cnt == LAST_BEAT);
    assign payload_ready = !rst && ((r_state == S_IDLE) ||
                                    ((r_state == S_SEND) && w_last && link_ready));
    assign w_accept      = payload_valid && payload_ready;
    assign w_beat_acc    = link_valid && link_ready;

    assign link_valid = (r_state == S_SEND);
    assign busy       = (r_state == S_SEND);
    assign link_first = (r_state == S_SEND) && (r_cnt == '0);
    assign link_last  = (r_state == S_SEND) && w_last;

    always_comb begin
        link_data = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                link_data = r_code[b*BEAT_W +: BEAT_W];
            end
        end
    end

    // A new word can only be accepted in SEND on the final accepted beat,
    // so accept takes priority and yields gap-free back-to-back words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else if (w_accept) begin
            r_state <= S_SEND;
            r_cnt   <= '0;
            r_code  <= w_code;
        end else if (w_beat_acc) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_three_of_six_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_three_of_six_tx
// Description : Directed literal checks plus randomized loopback against a
//               behavioural link model for every beat width.
// Revision    : 1.0
// ============================================================================
module tb_three_of_six_tx;

    localparam int NWORDS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each 3-bit group g becomes g*8 + (7-g): data on top, complement below.
    function automatic logic [47:0] cw(input logic [23:0] p);
        logic [47:0] c;
        logic [47:0] s;
        int g;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            g = int'((p >> (3*k)) & 24'h7);
            s = 48'(g*8 + (7 - g));
            c = c | (s << (6*k));
        end
        return c;
    endfunction

    function automatic logic [11:0] beat2(input logic [23:0] p, input int b);
        return 12'(cw(p) >> (12*b));
    endfunction

    // ---------------------------------------------------------------- directed
    logic        d_rst = 1'b1;
    logic        d_pv  = 1'b0;
    logic        d_lr  = 1'b1;
    logic [23:0] d_pin = '0;
    logic        d_pr, d_lv, d_lf, d_ll, d_bz;
    logic [11:0] d_ld;
    logic        d_acc;
    int          d_cnt;
    logic [23:0] d_w [3];
    logic [23:0] d_p;

    three_of_six_tx #(.SYMS_PER_BEAT(2)) dut (
        .clk           (clk),
        .rst           (d_rst),
        .payload_in    (d_pin),
        .payload_valid (d_pv),
        .payload_ready (d_pr),
        .link_data     (d_ld),
        .link_valid    (d_lv),
        .link_ready    (d_lr),
        .link_first    (d_lf),
        .link_last     (d_ll),
        .busy          (d_bz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input logic [23:0] p, input logic [11:0] e0, input logic [11:0] e1,
                            input logic [11:0] e2, input logic [11:0] e3);
        logic [11:0] e [4];
        e = '{e0, e1, e2, e3};
        d_pin = p; d_pv = 1'b1; d_lr = 1'b1;
        #1;
        chk("idle_ready", d_pr, 1'b1);
        step();
        d_pv = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            chk("lit_valid", d_lv, 1'b1);
            chk("lit_data",  d_ld, e[b]);
            chk("lit_first", d_lf, b == 0);
            chk("lit_last",  d_ll, b == 3);
            step();
            #1;
        end
        chk("lit_done", d_lv, 1'b0);
    endtask

    // ----------------------------------------------------- randomized loopback
    logic r_rst = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rand
            localparam int SPB = 1 << gi;
            localparam int NB  = 8 / SPB;
            localparam int BW  = 6 * SPB;

            logic [23:0]   pin = '0;
            logic          pv  = 1'b0;
            logic          lr  = 1'b0;
            logic          pr, lv, lf, ll, bz;
            logic [BW-1:0] ld;

            bit          m_busy = 1'b0;
            logic [23:0] m_word = '0;
            int          m_beat = 0;
            logic [23:0] sentq [$];
            logic [47:0] rx = '0;
            int          rx_beat = 0;
            int          ndec = 0;
            bit          acc_seen = 1'b0;
            bit          done = 1'b0;
            bit          exp_pr;
            logic [23:0] pay;
            logic [5:0]  sym;
            bit          err;
            int          sent;

            three_of_six_tx #(.SYMS_PER_BEAT(SPB)) u_dut (
                .clk           (clk),
                .rst           (r_rst),
                .payload_in    (pin),
                .payload_valid (pv),
                .payload_ready (pr),
                .link_data     (ld),
                .link_valid    (lv),
                .link_ready    (lr),
                .link_first    (lf),
                .link_last     (ll),
                .busy          (bz)
            );

            always @(negedge clk) begin
                if (!r_rst) begin
                    exp_pr = !m_busy || ((m_beat == NB-1) && lr);
                    chk($sformatf("s%0d_valid", SPB), lv, m_busy);
                    chk($sformatf("s%0d_busy",  SPB), bz, m_busy);
                    chk($sformatf("s%0d_ready", SPB), pr, exp_pr);
                    if (m_busy) begin
                        chk($sformatf("s%0d_data",  SPB), ld, BW'(cw(m_word) >> (BW*m_beat)));
                        chk($sformatf("s%0d_first", SPB), lf, m_beat == 0);
                        chk($sformatf("s%0d_last",  SPB), ll, m_beat == NB-1);
                    end
                    acc_seen = pv && pr;

                    // Far-end decoder: reassemble on first/last, check balance.
                    if (lv && lr) begin
                        if (lf) begin
                            rx = '0;
                            rx_beat = 0;
                        end
                        rx = rx | (48'(ld) << (BW*rx_beat));
                        rx_beat++;
                        if (ll) begin
                            pay = '0;
                            err = 1'b0;
                            for (int k = 0; k < 8; k++) begin
                                sym = 6'(rx >> (6*k));
                                if ($countones(sym) != 3 || sym[2:0] != ~sym[5:3]) err = 1'b1;
                                pay = pay | (24'(sym[5:3]) << (3*k));
                            end
                            chk($sformatf("s%0d_beats", SPB), rx_beat, NB);
                            chk($sformatf("s%0d_decerr", SPB), err, 1'b0);
                            if (sentq.size() == 0) begin
                                chk($sformatf("s%0d_spurious", SPB), pay, 24'hx);
                            end else begin
                                chk($sformatf("s%0d_payload", SPB), pay, sentq.pop_front());
                            end
                            ndec++;
                        end
                    end

                    if (m_busy && lr) begin
                        if (m_beat == NB-1) m_busy = 1'b0;
                        else m_beat++;
                    end
                    if (pv && exp_pr) begin
                        m_busy = 1'b1;
                        m_word = pin;
                        m_beat = 0;
                        sentq.push_back(pin);
                    end
                end
            end

            initial begin
                sent = 0;
                while (r_rst) @(posedge clk);
                while (sent < NWORDS) begin
                    @(posedge clk);
                    #1;
                    if (acc_seen) sent++;
                    if (!pv || acc_seen) begin
                        pv  = (sent < NWORDS) && ($urandom % 10 < 7);
                        pin = 24'($urandom);
                    end
                    lr = ($urandom % 4) != 0;
                end
                pv = 1'b0;
                lr = 1'b1;
                for (int c = 0; c < 50 && m_busy; c++) @(posedge clk);
                @(posedge clk);
                #1;
                chk($sformatf("s%0d_ndec", SPB), ndec, NWORDS);
                chk($sformatf("s%0d_drained", SPB), sentq.size(), 0);
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        repeat (3) @(posedge clk);
        #1;
        r_rst = 1'b0;
    end

    // ----------------------------------------------------------------- main
    initial begin
        d_rst = 1'b1;
        step();
        step();
        chk("rst_valid", d_lv, 1'b0);
        chk("rst_data",  d_ld, 12'h000);
        chk("rst_ready", d_pr, 1'b0);
        chk("rst_busy",  d_bz, 1'b0);
        chk("rst_first", d_lf, 1'b0);
        chk("rst_last",  d_ll, 1'b0);
        d_rst = 1'b0;
        #1;
        chk("post_rst_ready", d_pr, 1'b1);

        send_lit(24'h000000, 12'h1C7, 12'h1C7, 12'h1C7, 12'h1C7);
        send_lit(24'hFFFFFF, 12'hE38, 12'hE38, 12'hE38, 12'hE38);
        send_lit(24'h000005, 12'h1EA, 12'h1C7, 12'h1C7, 12'h1C7);

        // Backpressure on beat 1 for three cycles.
        d_p = 24'h9AC35B;
        d_pin = d_p; d_pv = 1'b1;
        #1;
        step();
        d_pv = 1'b0;
        #1;
        chk("bp_beat0", d_ld, beat2(d_p, 0));
        step();
        d_lr = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data",  d_ld, beat2(d_p, 1));
            chk("bp_hold_valid", d_lv, 1'b1);
            chk("bp_hold_ready", d_pr, 1'b0);
            step();
        end
        d_lr = 1'b1;
        #1;
        chk("bp_beat1", d_ld, beat2(d_p, 1));
        step();
        chk("bp_beat2", d_ld, beat2(d_p, 2));
        step();
        chk("bp_beat3", d_ld, beat2(d_p, 3));
        chk("bp_last",  d_ll, 1'b1);
        chk("bp_ready_last", d_pr, 1'b1);
        step();
        chk("bp_done", d_lv, 1'b0);

        // Back-to-back: three words, twelve contiguous beats.
        for (int i = 0; i < 3; i++) d_w[i] = 24'($urandom);
        d_cnt = 0;
        d_pin = d_w[0]; d_pv = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) begin
            d_acc = d_pv && d_pr;
            step();
            if (d_acc) begin
                d_cnt++;
                if (d_cnt < 3) d_pin = d_w[d_cnt];
                else d_pv = 1'b0;
            end
            #1;
            if (i < 12) begin
                chk("b2b_valid", d_lv, 1'b1);
                chk("b2b_data",  d_ld, beat2(d_w[i/4], i % 4));
                chk("b2b_first", d_lf, (i % 4) == 0);
                chk("b2b_last",  d_ll, (i % 4) == 3);
            end else begin
                chk("b2b_done", d_lv, 1'b0);
            end
        end

        // Reset at beat 2 abandons the word.
        d_p = 24'h5A5A5A;
        d_pin = d_p; d_pv = 1'b1;
        #1;
        step();
        d_pv = 1'b0;
        #1;
        step();
        step();
        chk("mid_beat2", d_ld, beat2(d_p, 2));
        d_rst = 1'b1;
        #1;
        chk("mid_rst_ready", d_pr, 1'b0);
        step();
        chk("mid_rst_valid", d_lv, 1'b0);
        chk("mid_rst_busy",  d_bz, 1'b0);
        chk("mid_rst_data",  d_ld, 12'h000);
        d_rst = 1'b0;
        #1;
        chk("mid_post_ready", d_pr, 1'b1);
        step();
        chk("mid_no_resume", d_lv, 1'b0);
        send_lit(24'h000005, 12'h1EA, 12'h1C7, 12'h1C7, 12'h1C7);

        for (int c = 0; c < 60000; c++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done) break;
            @(posedge clk);
        end
        chk("rand_done", {g_rand[3].done, g_rand[2].done, g_rand[1].done, g_rand[0].done}, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
